// File: rtl/Purple_Jade_pkg.sv
// Shared types and default parameters for the reorder buffer (rob_mc).
package Purple_Jade_pkg;
  localparam int ROB_DEPTH_D = 16;
  localparam int NUM_WB_D    = 4;
  localparam int COMMIT_W_D  = 2;
  localparam int PC_W_D      = 16;
  localparam int TAG_W_D     = 6;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} rob_state_e;

  typedef struct packed {
    logic [PC_W_D-1:0]  pc;
    logic [PC_W_D-1:0]  pred_pc;
    logic               is_branch;
    logic               is_store;
    logic               w_v;
    logic [TAG_W_D-1:0] alloc_reg;
    logic [TAG_W_D-1:0] freed_reg;
  } rob_alloc_t;

  typedef struct packed {
    logic [PC_W_D-1:0]  pc;
    logic               is_store;
    logic               w_v;
    logic [TAG_W_D-1:0] alloc_reg;
    logic [TAG_W_D-1:0] freed_reg;
  } rob_commit_t;

  function automatic rob_commit_t to_commit(rob_alloc_t a);
    return '{pc: a.pc, is_store: a.is_store, w_v: a.w_v,
             alloc_reg: a.alloc_reg, freed_reg: a.freed_reg};
  endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// Picks the retiring prefix of the head window: valid+wb, one store max,
// stopping after the first mispredicted branch.
module rob_commit_sel
  import Purple_Jade_pkg::*;
#(
  parameter int COMMIT_W = COMMIT_W_D,
  parameter int SLOT_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
  input  logic [COMMIT_W-1:0] valid_i,
  input  logic [COMMIT_W-1:0] wb_i,
  input  logic [COMMIT_W-1:0] store_i,
  input  logic [COMMIT_W-1:0] misp_i,
  output logic [COMMIT_W-1:0] retire_o,
  output logic                misp_o,
  output logic [SLOT_W-1:0]   misp_slot_o
);
  logic open, st_seen;

  always_comb begin
    retire_o    = '0;
    misp_o      = 1'b0;
    misp_slot_o = '0;
    open        = 1'b1;
    st_seen     = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (open && valid_i[k] && wb_i[k] && !(store_i[k] && st_seen)) begin
        retire_o[k] = 1'b1;
        st_seen     = st_seen | store_i[k];
        if (misp_i[k]) begin
          misp_o      = 1'b1;
          misp_slot_o = SLOT_W'(k);
          open        = 1'b0;
        end
      end else begin
        open = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rob_mc.sv
// Reorder buffer with multi-port writeback, in-order multi-commit and
// branch-mispredict flush. Optional perf counters: ROB_PERF_CNT_EN.
module rob_mc
  import Purple_Jade_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_D,
  parameter int NUM_WB    = NUM_WB_D,
  parameter int COMMIT_W  = COMMIT_W_D,
  parameter int PC_W      = PC_W_D,
  parameter int TAG_W     = TAG_W_D,
  localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             alloc_valid_i,
  output logic                             alloc_ready_o,
  input  rob_alloc_t                       alloc_entry_i,
  output logic [IDX_W-1:0]                 alloc_idx_o,
  input  logic [NUM_WB-1:0]                wb_valid_i,
  input  logic [NUM_WB-1:0][IDX_W-1:0]     wb_idx_i,
  input  logic [NUM_WB-1:0][PC_W-1:0]      wb_target_i,
  output logic [COMMIT_W-1:0]              commit_valid_o,
  output rob_commit_t [COMMIT_W-1:0]       commit_entry_o,
  output logic                             flush_o,
  output logic [PC_W-1:0]                  flush_pc_o,
  output logic [IDX_W:0]                   occupancy_o
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_commit_cnt_o,
  output logic [31:0]                      perf_flush_cnt_o
`endif
);
  localparam int SLOT_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

  // Struct fields are sized by the package, so overrides must agree with it.
  if (PC_W != PC_W_D || TAG_W != TAG_W_D) begin : g_bad_width
    $error("rob_mc: PC_W/TAG_W must match Purple_Jade_pkg");
  end
  if (ROB_DEPTH < 4 || (ROB_DEPTH & (ROB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rob_mc: ROB_DEPTH must be a power of two >= 4");
  end

  rob_alloc_t             ent_q [ROB_DEPTH];
  logic [PC_W-1:0]        tgt_q [ROB_DEPTH];
  logic [PC_W-1:0]        tgt_d [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]   valid_q, valid_d, wb_q, wb_d;
  logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]         count_q, count_d, ret_cnt;
  logic [PC_W-1:0]        flush_pc_q, flush_pc_d;
  rob_state_e             state_q, state_d;

  logic [COMMIT_W-1:0][IDX_W-1:0] win_idx;
  logic [COMMIT_W-1:0]    win_v, win_wb, win_st, win_mp, retire;
  logic                   misp, run, alloc_fire, flush_now;
  logic [SLOT_W-1:0]      misp_slot;

  always_comb begin
    for (int k = 0; k < COMMIT_W; k++) begin
      win_idx[k]        = head_q + IDX_W'(k);
      win_v[k]          = valid_q[win_idx[k]];
      win_wb[k]         = wb_q[win_idx[k]];
      win_st[k]         = ent_q[win_idx[k]].is_store;
      win_mp[k]         = ent_q[win_idx[k]].is_branch & wb_q[win_idx[k]] &
                          (tgt_q[win_idx[k]] != ent_q[win_idx[k]].pred_pc);
      commit_entry_o[k] = to_commit(ent_q[win_idx[k]]);
    end
  end

  rob_commit_sel #(.COMMIT_W(COMMIT_W), .SLOT_W(SLOT_W)) u_sel (
    .valid_i     (win_v),
    .wb_i        (win_wb),
    .store_i     (win_st),
    .misp_i      (win_mp),
    .retire_o    (retire),
    .misp_o      (misp),
    .misp_slot_o (misp_slot)
  );

  assign run            = (state_q == RUN);
  assign commit_valid_o = run ? retire : '0;
  assign flush_now      = run & misp;
  assign alloc_ready_o  = run & (count_q != (IDX_W+1)'(ROB_DEPTH));
  assign alloc_fire     = alloc_valid_i & alloc_ready_o;
  assign alloc_idx_o    = tail_q;
  assign occupancy_o    = count_q;
  assign flush_o        = (state_q == FLUSH);
  assign flush_pc_o     = flush_pc_q;

  always_comb begin
    ret_cnt = '0;
    for (int k = 0; k < COMMIT_W; k++) ret_cnt = ret_cnt + (IDX_W+1)'(commit_valid_o[k]);
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    wb_d       = wb_q;
    tgt_d      = tgt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_pc_d = flush_pc_q;
    if (state_q == FLUSH) begin
      state_d = RUN;
    end else if (flush_now) begin
      state_d    = FLUSH;
      valid_d    = '0;
      wb_d       = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_pc_d = tgt_q[win_idx[misp_slot]];
    end else begin
      // Descending so the lowest port's target is the one that sticks.
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && valid_q[wb_idx_i[p]] && !wb_q[wb_idx_i[p]]) begin
          wb_d[wb_idx_i[p]]  = 1'b1;
          tgt_d[wb_idx_i[p]] = wb_target_i[p];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid_o[k]) begin
          valid_d[win_idx[k]] = 1'b0;
          wb_d[win_idx[k]]    = 1'b0;
        end
      end
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        wb_d[tail_q]    = 1'b0;
      end
      head_d  = head_q + ret_cnt[IDX_W-1:0];
      tail_d  = tail_q + IDX_W'(alloc_fire);
      count_d = count_q + (IDX_W+1)'(alloc_fire) - ret_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RUN;
      valid_q    <= '0;
      wb_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_pc_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      wb_q       <= wb_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_pc_q <= flush_pc_d;
      tgt_q      <= tgt_d;
      if (alloc_fire && !flush_now) ent_q[tail_q] <= alloc_entry_i;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_q, perf_flush_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_commit_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_commit_q <= perf_commit_q + 32'(ret_cnt);
      if (flush_now) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end
  assign perf_commit_cnt_o = perf_commit_q;
  assign perf_flush_cnt_o  = perf_flush_q;
`endif
endmodule

// File: tb/tb_rob_mc.sv
// Bench for rob_mc: queue-based reference ROB checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rob_mc;
  import Purple_Jade_pkg::*;
  localparam int DEPTH = 16;
  localparam int NWB   = 4;
  localparam int CW    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     alloc_v, alloc_rdy;
  rob_alloc_t               alloc_e;
  logic [3:0]               alloc_idx;
  logic [NWB-1:0]           wb_v;
  logic [NWB-1:0][3:0]      wb_idx;
  logic [NWB-1:0][15:0]     wb_tgt;
  logic [CW-1:0]            cv;
  rob_commit_t [CW-1:0]     ce;
  logic                     flush;
  logic [15:0]              flush_pc;
  logic [4:0]               occ;

  always #5 clk = ~clk;

  rob_mc dut (
    .clk_i(clk), .reset_i(rst),
    .alloc_valid_i(alloc_v), .alloc_ready_o(alloc_rdy), .alloc_entry_i(alloc_e),
    .alloc_idx_o(alloc_idx),
    .wb_valid_i(wb_v), .wb_idx_i(wb_idx), .wb_target_i(wb_tgt),
    .commit_valid_o(cv), .commit_entry_o(ce),
    .flush_o(flush), .flush_pc_o(flush_pc), .occupancy_o(occ)
  );

  int pass_cnt = 0, tot_cnt = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference: the ROB is a queue of in-flight instructions, oldest first.
  typedef struct {
    int          idx;
    rob_alloc_t  e;
    bit          wb;
    logic [15:0] tgt;
  } ment_t;
  ment_t       mq[$];
  int          mtail;
  bit          mflush;
  logic [15:0] mfpc;

  function automatic void m_retire(output int n, output bit misp);
    bit st = 0;
    n = 0;
    misp = 0;
    while (n < mq.size() && n < CW) begin
      if (!mq[n].wb || (mq[n].e.is_store && st)) break;
      st = st | mq[n].e.is_store;
      n++;
      if (mq[n-1].e.is_branch && mq[n-1].tgt != mq[n-1].e.pred_pc) begin
        misp = 1;
        break;
      end
    end
  endfunction

  task automatic m_step();
    int n;
    bit mp, acc;
    if (rst) begin
      mq.delete(); mtail = 0; mflush = 0; mfpc = '0;
    end else if (mflush) begin
      mflush = 0;
    end else begin
      m_retire(n, mp);
      if (mp) begin
        mfpc = mq[n-1].tgt; mflush = 1; mq.delete(); mtail = 0;
      end else begin
        acc = alloc_v && (mq.size() < DEPTH);
        foreach (mq[j]) begin
          if (!mq[j].wb) begin
            for (int p = 0; p < NWB; p++) begin
              if (wb_v[p] && int'(wb_idx[p]) == mq[j].idx) begin
                mq[j].wb = 1; mq[j].tgt = wb_tgt[p];
                break;
              end
            end
          end
        end
        repeat (n) void'(mq.pop_front());
        if (acc) begin
          mq.push_back('{idx: mtail, e: alloc_e, wb: 1'b0, tgt: 16'h0});
          mtail = (mtail + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  always @(negedge clk) begin : cmp
    int n;
    bit mp;
    logic [CW-1:0] ev;
    rob_commit_t ec;
    if (chk_en) begin
      n = 0;
      if (!mflush) m_retire(n, mp);
      ev = '0;
      for (int k = 0; k < n; k++) ev[k] = 1'b1;
      chk("alloc_ready", alloc_rdy, !mflush && mq.size() < DEPTH);
      chk("alloc_idx", alloc_idx, mtail);
      chk("occupancy", occ, mq.size());
      chk("flush", flush, mflush);
      chk("flush_pc", flush_pc, mfpc);
      chk("commit_valid", cv, ev);
      for (int k = 0; k < n; k++) begin
        ec = '{pc: mq[k].e.pc, is_store: mq[k].e.is_store, w_v: mq[k].e.w_v,
               alloc_reg: mq[k].e.alloc_reg, freed_reg: mq[k].e.freed_reg};
        chk("commit_entry", ce[k], ec);
      end
    end
  end

  function automatic rob_alloc_t mk(logic [15:0] pc, logic br, logic st, logic [15:0] pred);
    rob_alloc_t a;
    a = '0;
    a.pc = pc; a.pred_pc = pred; a.is_branch = br; a.is_store = st; a.w_v = 1'b1;
    a.alloc_reg = pc[5:0]; a.freed_reg = ~pc[5:0];
    return a;
  endfunction

  task automatic quiet();
    alloc_v = 0; wb_v = '0; wb_idx = '0; wb_tgt = '0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    int wexp[4];
    wexp = '{15, 0, 1, 2};
    alloc_e = '0;
    quiet();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    chk("reset_ready", alloc_rdy, 1);
    chk("reset_idx", alloc_idx, 0);
    chk("reset_cv", cv, 0);
    chk("reset_flush", flush, 0);
    chk("reset_occ", occ, 0);

    // Fill to 16 with no writebacks; 17th must bounce.
    for (int i = 0; i < 16; i++) begin
      alloc_v = 1; alloc_e = mk(16'h100 + 16'(i), 0, 0, 16'h0); tick();
    end
    chk("full_occ", occ, 16);
    chk("full_ready", alloc_rdy, 0);
    alloc_e = mk(16'h1ff, 0, 0, 16'h0); tick();
    chk("full17_occ", occ, 16);
    chk("full17_idx", alloc_idx, 0);
    alloc_v = 0;

    // Out-of-order writeback 3,2,1,0: nothing retires until entry 0 is done.
    for (int i = 3; i >= 0; i--) begin
      wb_v = 4'b0001; wb_idx[0] = 4'(i); tick();
      if (i != 0) chk("ooo_hold_cv", cv, 0);
    end
    chk("ooo_cv1", cv, 2'b11);
    chk("ooo_pc0", ce[0].pc, 16'h100);
    chk("ooo_pc1", ce[1].pc, 16'h101);
    wb_v = '0; tick();
    chk("ooo_cv2", cv, 2'b11);
    chk("ooo_pc2", ce[0].pc, 16'h102);
    chk("ooo_occ14", occ, 14);
    tick();
    chk("ooo_cv3", cv, 0);
    chk("ooo_occ12", occ, 12);

    // Two stores at head retire one per cycle.
    do_reset();
    alloc_v = 1; alloc_e = mk(16'h200, 0, 1, 16'h0); tick();
    alloc_e = mk(16'h201, 0, 1, 16'h0); tick();
    alloc_v = 0; wb_v = 4'b0011; wb_idx[0] = 4'd0; wb_idx[1] = 4'd1; tick();
    chk("st_cv1", cv, 2'b01);
    chk("st_pc1", ce[0].pc, 16'h200);
    wb_v = '0; tick();
    chk("st_cv2", cv, 2'b01);
    chk("st_pc2", ce[0].pc, 16'h201);
    tick();
    chk("st_occ", occ, 0);

    // Mispredict on entry 1; port 1 beats port 3 on the same entry.
    do_reset();
    alloc_v = 1; alloc_e = mk(16'h300, 0, 0, 16'h0); tick();
    alloc_e = mk(16'h301, 1, 0, 16'h0040); tick();
    alloc_e = mk(16'h302, 0, 0, 16'h0); tick();
    alloc_v = 0;
    wb_v = 4'b1111; wb_idx = '{4'd1, 4'd2, 4'd1, 4'd0};
    wb_tgt = '{16'h0040, 16'h0, 16'h0080, 16'h0};
    tick();
    chk("mp_cv", cv, 2'b11);
    chk("mp_noflush", flush, 0);
    alloc_v = 1; alloc_e = mk(16'h3aa, 0, 0, 16'h0); wb_v = 4'b0001; wb_idx = '0;
    tick();
    chk("mp_flush", flush, 1);
    chk("mp_flush_pc", flush_pc, 16'h0080);
    chk("mp_occ", occ, 0);
    chk("mp_ready", alloc_rdy, 0);
    chk("mp_cv_fl", cv, 0);
    tick();
    chk("mp_flush_off", flush, 0);
    chk("mp_pc_hold", flush_pc, 16'h0080);
    chk("mp_occ2", occ, 0);
    chk("mp_ready2", alloc_rdy, 1);
    quiet();

    // Tail wrap 15,0,1,2 and writeback to a freed slot being ignored.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      alloc_v = 1; alloc_e = mk(16'h400 + 16'(i), 0, 0, 16'h0); tick();
    end
    alloc_v = 0;
    chk("wrap_idx15", alloc_idx, 15);
    chk("wrap_occ15", occ, 15);
    wb_v = 4'b1111; wb_idx = '{4'd3, 4'd2, 4'd1, 4'd0}; tick();
    wb_v = '0; tick(); tick();
    chk("wrap_occ11", occ, 11);
    wb_v = 4'b0001; wb_idx[0] = 4'd1; tick();
    wb_v = '0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_alloc_idx", alloc_idx, wexp[i]);
      alloc_v = 1; alloc_e = mk(16'h4f0 + 16'(i), 0, 0, 16'h0); tick();
    end
    alloc_v = 0;
    chk("wrap_occ_after", occ, 15);
    for (int i = 4; i <= 16; i++) begin
      wb_v = 4'b0001; wb_idx[0] = 4'(i % 16); tick();
    end
    wb_v = '0;
    repeat (4) tick();
    chk("wrap_stall_occ", occ, 2);
    chk("wrap_stall_cv", cv, 0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      alloc_v = ($urandom_range(0, 9) < 6);
      alloc_e = mk(16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 16'h0040);
      alloc_e.w_v = 1'($urandom);
      alloc_e.alloc_reg = 6'($urandom);
      alloc_e.freed_reg = 6'($urandom);
      for (int p = 0; p < NWB; p++) begin
        wb_v[p]   = ($urandom_range(0, 2) == 0);
        wb_idx[p] = (mq.size() > 0) ? 4'((mq[0].idx + $urandom_range(0, 5)) % DEPTH) : 4'($urandom);
        wb_tgt[p] = ($urandom_range(0, 3) == 0) ? 16'h0080 : 16'h0040;
      end
      tick();
    end
    rst = 0;
    quiet();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
